// File: rtl/memory_access_controller.sv
// memory_access_controller
//   Runs byte, halfword and word requests from the control unit as 1, 2 or 4
//   sequential byte beats on a byte-wide RAM. Each beat lasts WAIT_STATES+1
//   cycles. MFC is raised when the access completes.
//
//   Optional feature (macro MAC_ALIGN_CHECK_EN): a misaligned request is
//   answered at once with Fault=1 and MFC=1 and never touches the RAM.
//   When the macro is undefined, Fault is tied to 0.
//
// Parameters
//   WAIT_STATES  extra cycles per beat (0..7)
//   ADDR_W       memory address width
//
// Ports
//   CLK, Reset                  clock; asynchronous active-low reset
//   MOV, RW, Size, Addr, DataIn request from the control word, MAR and MDR
//   DataOut, MFC, Busy, Fault   result and status returned to the control unit
//   MemEn, MemWE, MemAddr,
//   MemWData, MemRData          byte-wide RAM port
module memory_access_controller #(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned ADDR_W      = 8
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              MOV,
  input  logic              RW,
  input  logic [1:0]        Size,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [31:0]       DataIn,
  output logic [31:0]       DataOut,
  output logic              MFC,
  output logic              Busy,
  output logic              Fault,
  output logic              MemEn,
  output logic              MemWE,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [7:0]        MemWData,
  input  logic [7:0]        MemRData
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state, state_nxt;
  logic              rw_q;
  logic [1:0]        last_q;
  logic [1:0]        beat_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       data_out_q;
  logic              accept;
  logic              beat_end;
  logic              misaligned;

  assign accept   = (state == IDLE) && MOV;
  assign beat_end = (state == ACCESS) && (cnt_q == '0);

`ifdef MAC_ALIGN_CHECK_EN
  logic fault_q;

  assign misaligned = ((Size == 2'b01) && Addr[0]) ||
                      (Size[1] && (Addr[1:0] != 2'b00));

  // Fault is raised at acceptance and held until the next accepted request.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      fault_q <= 1'b0;
    end else if (accept) begin
      fault_q <= misaligned;
    end
  end

  assign Fault = fault_q;
`else
  assign misaligned = 1'b0;
  assign Fault      = 1'b0;
`endif

  // State register
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (MOV) state_nxt = misaligned ? DONE : ACCESS;
      ACCESS:  if (beat_end && (beat_q == last_q)) state_nxt = DONE;
      DONE:    if (!MOV) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from registered state only, so MOV has no path to them.
  always_comb begin
    MFC      = 1'b0;
    Busy     = 1'b0;
    MemEn    = 1'b0;
    MemWE    = 1'b0;
    MemAddr  = '0;
    MemWData = '0;
    MFC      = (state == DONE);
    Busy     = (state != IDLE);
    if (state == ACCESS) begin
      MemEn    = 1'b1;
      MemWE    = beat_end && !rw_q;
      MemAddr  = addr_q + ADDR_W'(beat_q);
      MemWData = 8'(wdata_q >> {beat_q, 3'b000});
    end
  end

  // Request capture, beat/wait sequencing and read-data assembly
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      rw_q       <= 1'b0;
      last_q     <= '0;
      beat_q     <= '0;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      data_out_q <= '0;
    end else if (accept) begin
      rw_q       <= RW;
      addr_q     <= Addr;
      wdata_q    <= DataIn;
      data_out_q <= '0;
      beat_q     <= '0;
      cnt_q      <= CNT_W'(WAIT_STATES);
      case (Size)
        2'b00:   last_q <= 2'd0;
        2'b01:   last_q <= 2'd1;
        default: last_q <= 2'd3;
      endcase
    end else if (state == ACCESS) begin
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end else begin
        if (rw_q) begin
          for (int k = 0; k < 4; k++) begin
            if (beat_q == 2'(k)) data_out_q[8*k +: 8] <= MemRData;
          end
        end
        if (beat_q != last_q) begin
          beat_q <= beat_q + 2'd1;
          cnt_q  <= CNT_W'(WAIT_STATES);
        end
      end
    end
  end

  assign DataOut = data_out_q;

endmodule

// File: tb/tb_memory_access_controller.sv
// Self-checking bench for memory_access_controller: directed cases from the
// block's test plan followed by randomized requests, all checked against a
// cycle-count/byte-array reference model.
module tb_memory_access_controller;

  localparam int unsigned WS     = 2;
  localparam int unsigned ADDR_W = 8;
`ifdef MAC_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic              mov;
  logic              rw;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       data_in;
  logic [31:0]       data_out;
  logic              mfc;
  logic              busy;
  logic              fault;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  logic [7:0] ram [256];
  int n_cmp = 0;
  int n_err = 0;

  memory_access_controller #(.WAIT_STATES(WS), .ADDR_W(ADDR_W)) dut (
    .CLK      (clk),
    .Reset    (rst_n),
    .MOV      (mov),
    .RW       (rw),
    .Size     (size),
    .Addr     (addr),
    .DataIn   (data_in),
    .DataOut  (data_out),
    .MFC      (mfc),
    .Busy     (busy),
    .Fault    (fault),
    .MemEn    (mem_en),
    .MemWE    (mem_we),
    .MemAddr  (mem_addr),
    .MemWData (mem_wdata),
    .MemRData (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte-wide RAM model
  assign mem_rdata = ram[mem_addr];
  always @(posedge clk) begin
    if (mem_en && mem_we) ram[mem_addr] = mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One complete request, entered and left at a negedge.
  task automatic run_access(input logic r, input logic [1:0] sz, input logic [7:0] a,
                            input logic [31:0] wd, input int hold, input bit drop_early);
    int n;
    int len;
    bit mis;
    logic [31:0] exp_rd;
    logic [7:0] b;
    logic we_exp;
    n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    mis = ALIGN_EN && (((sz == 2'd1) && a[0]) || (sz[1] && (a[1:0] != 2'b00)));
    exp_rd = '0;
    for (int k = 0; k < n; k++) begin
      b = 8'(a + 8'(k));
      exp_rd = exp_rd | (32'(ram[b]) << (8 * k));
    end
    mov = 1'b1; rw = r; size = sz; addr = a; data_in = wd;
    @(posedge clk); // e0
    if (!mis) begin
      len = n * (WS + 1);
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        if (c == 0) begin
          rw = 1'($urandom); size = 2'($urandom); addr = 8'($urandom); data_in = $urandom;
          if (drop_early) mov = 1'b0;
        end
        check("busy_acc", 32'(busy), 32'd1);
        check("mfc_acc", 32'(mfc), 32'd0);
        check("en_acc", 32'(mem_en), 32'd1);
        check("addr_acc", 32'(mem_addr), 32'(8'(a + 8'(c / (WS + 1)))));
        we_exp = !r && ((c % (WS + 1)) == WS);
        check("we_acc", 32'(mem_we), 32'(we_exp));
        if (we_exp) check("wdata_acc", 32'(mem_wdata), 32'(wd[8*(c/(WS+1)) +: 8]));
        @(posedge clk);
      end
    end
    @(negedge clk);
    check("mfc_done", 32'(mfc), 32'd1);
    check("busy_done", 32'(busy), 32'd1);
    check("en_done", 32'(mem_en), 32'd0);
    check("we_done", 32'(mem_we), 32'd0);
    check("fault_done", 32'(fault), 32'(mis));
    check("dout_done", data_out, (r && !mis) ? exp_rd : 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      check("mfc_hold", 32'(mfc), 32'd1);
      check("en_hold", 32'(mem_en), 32'd0);
    end
    mov = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mfc_idle", 32'(mfc), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    check("en_idle", 32'(mem_en), 32'd0);
    check("dout_idle", data_out, (r && !mis) ? exp_rd : 32'd0);
    check("fault_idle", 32'(fault), 32'(mis));
    if (!r && !mis) begin
      for (int k = 0; k < n; k++) begin
        b = 8'(a + 8'(k));
        check("ram_wr", 32'(ram[b]), 32'(wd[8*k +: 8]));
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dout"}, data_out, 32'd0);
    check({tag, "_mfc"}, 32'(mfc), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_fault"}, 32'(fault), 32'd0);
    check({tag, "_en"}, 32'(mem_en), 32'd0);
    check({tag, "_we"}, 32'(mem_we), 32'd0);
    check({tag, "_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
  endtask

  initial begin
    logic [7:0] old41;
    logic [7:0] old42;
    for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
    ram[8'h10] = 8'h11; ram[8'h11] = 8'h22; ram[8'h12] = 8'h33; ram[8'h13] = 8'h44;
    rst_n = 1'b0; mov = 1'b0; rw = 1'b0; size = 2'd0; addr = '0; data_in = '0;
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    run_access(1'b1, 2'd2, 8'h10, 32'h0, 0, 1'b0);
    check("word_rd_0x10", data_out, 32'h44332211);
    run_access(1'b0, 2'd1, 8'h20, 32'hAABBCCDD, 0, 1'b0);
    run_access(1'b1, 2'd2, 8'h10, 32'h0, 0, 1'b0);
    run_access(1'b1, 2'd0, 8'hFF, 32'h0, 0, 1'b0);
    check("byte_rd_0xff", data_out, 32'(ram[8'hFF]));
    run_access(1'b1, 2'd2, 8'hFE, 32'h0, 0, 1'b0);
    run_access(1'b1, 2'd1, 8'h30, 32'h0, 5, 1'b0);
    run_access(1'b0, 2'd2, 8'h50, 32'h12345678, 0, 1'b1);
    run_access(1'b1, 2'd2, 8'h03, 32'h0, 0, 1'b0);
    run_access(1'b1, 2'd3, 8'h60, 32'h0, 1, 1'b0);

    // Reset during the second beat of a word write
    old41 = ram[8'h41];
    old42 = ram[8'h42];
    mov = 1'b1; rw = 1'b0; size = 2'd2; addr = 8'h40; data_in = 32'hCAFEF00D;
    @(posedge clk);
    for (int c = 0; c < int'(WS) + 2; c++) begin
      @(negedge clk);
      if (c < int'(WS) + 1) @(posedge clk);
    end
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    mov = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("midrst_we", 32'(mem_we), 32'd0);
    end
    check("midrst_ram40", 32'(ram[8'h40]), 32'h0D);
    check("midrst_ram41", 32'(ram[8'h41]), 32'(old41));
    check("midrst_ram42", 32'(ram[8'h42]), 32'(old42));
    rst_n = 1'b1;
    @(negedge clk);
    run_access(1'b0, 2'd2, 8'h40, 32'h01020304, 0, 1'b0);

    // Randomized requests
    for (int i = 0; i < 40; i++) begin
      int hold;
      bit drop;
      hold = int'($urandom_range(0, 2));
      drop = (hold == 0) && ($urandom_range(0, 1) == 1);
      run_access(1'($urandom), 2'($urandom), 8'($urandom), $urandom, hold, drop);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
